// File: rtl/ticket_issuer_pkg.sv
// Shared ticket/queue definitions: issue FSM encoding
// and ticket-number wrap helpers.
package ticket_issuer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam int TKT_FIRST = 1;

  // Last ticket before wrapping back to TKT_FIRST
  function automatic int tkt_last(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Request buffer: registered occupancy, head visible
// combinationally, push into a full buffer only alongside a pop.
module req_fifo
  import ticket_issuer_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(D+1)-1:0]     cnt,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] rp;
  logic [AW-1:0] wp;
  logic          do_pop;
  logic          do_push;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(D));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= nxt(wp);
      if (do_pop)  rp <= nxt(rp);
      if (do_push && !do_pop)
        cnt <= cnt + 1'b1;
      else if (do_pop && !do_push)
        cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/ticket_issuer.sv
// Kiosk ticket issuer: numbers accepted requests, buffers
// them and paces one-cycle customer pulses with a hold gap.
module ticket_issuer
  import ticket_issuer_pkg::*;
#(
  parameter int DT_SZ = 4,
  parameter int QDEP  = 2,
  parameter int GAP   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req,
  input  logic [DT_SZ-1:0]          req_time,
  input  logic                      issue_en,
  output logic                      out_valid,
  output logic [DT_SZ-1:0]          out_num,
  output logic [DT_SZ-1:0]          out_time,
  output logic [$clog2(QDEP+1)-1:0] pend_cnt,
  output logic                      rej,
  output logic                      ovf
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t               st;
  logic [GW-1:0]        hcnt;
  logic [DT_SZ-1:0]     tkt;
  logic [2*DT_SZ-1:0]   head;
  logic                 full;
  logic                 empty;
  logic                 good;
  logic                 pop;
  logic                 acc;

  assign good = req && (req_time != '0);
  // The issued entry stays at the head until ISSUE ends
  assign pop  = (st == S_ISSUE);
  assign acc  = good && (!full || pop);

  req_fifo #(
    .W (2 * DT_SZ),
    .D (QDEP)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (acc),
    .pop   (pop),
    .din   ({tkt, req_time}),
    .dout  (head),
    .cnt   (pend_cnt),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      st        <= S_IDLE;
      hcnt      <= '0;
      tkt       <= DT_SZ'(TKT_FIRST);
      out_valid <= 1'b0;
      out_num   <= '0;
      out_time  <= '0;
      rej       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      rej       <= req && !acc;
      out_valid <= 1'b0;
      out_num   <= '0;
      out_time  <= '0;
      if (good && full && !pop) ovf <= 1'b1;
      if (acc) begin
        if (int'(tkt) == tkt_last(DT_SZ))
          tkt <= DT_SZ'(TKT_FIRST);
        else
          tkt <= tkt + 1'b1;
      end
      unique case (st)
        S_IDLE: begin
          // Empty buffer: issue straight from the incoming request
          if (issue_en && (!empty || acc)) begin
            st        <= S_ISSUE;
            out_valid <= 1'b1;
            {out_num, out_time} <= empty ? {tkt, req_time} : head;
          end
        end
        S_ISSUE: begin
          hcnt <= '0;
          st   <= (GAP == 0) ? S_IDLE : S_HOLD;
        end
        S_HOLD: begin
          if (int'(hcnt) >= GAP - 1)
            st <= S_IDLE;
          else
            hcnt <= hcnt + 1'b1;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ticket_issuer.sv
// Scoreboard bench for ticket_issuer (DT_SZ=4, QDEP=2, GAP=1).
module tb_ticket_issuer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [3:0] req_time = '0;
  logic       issue_en = 1'b1;
  logic       out_valid;
  logic [3:0] out_num;
  logic [3:0] out_time;
  logic [1:0] pend_cnt;
  logic       rej;
  logic       ovf;

  int checks = 0;
  int failures = 0;
  int npulse = 0;
  logic [7:0] exp_q [$];
  logic [3:0] exp_tkt = 4'd1;

  ticket_issuer #(
    .DT_SZ (4),
    .QDEP  (2),
    .GAP   (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_time  (req_time),
    .issue_en  (issue_en),
    .out_valid (out_valid),
    .out_num   (out_num),
    .out_time  (out_time),
    .pend_cnt  (pend_cnt),
    .rej       (rej),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    logic [7:0] e;
    #1;
    if (!rst_n) begin
      if (out_valid) begin
        npulse++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pulse_unexpected num=%0d time=%0d required=no pulse",
                   out_num, out_time);
        end else begin
          e = exp_q.pop_front();
          if ({out_num, out_time} !== e) begin
            failures++;
            $display("FAIL pulse_data num=%0d time=%0d required num=%0d time=%0d",
                     out_num, out_time, e[7:4], e[3:0]);
          end
        end
        checks++;
        if (out_num === 4'd0) begin
          failures++;
          $display("FAIL ticket_zero num=%0d required nonzero", out_num);
        end
      end else begin
        checks++;
        if (out_num !== 4'd0 || out_time !== 4'd0) begin
          failures++;
          $display("FAIL idle_zero num=%0d time=%0d required 0 0",
                   out_num, out_time);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [3:0] t, input bit accept);
    req      = 1'b1;
    req_time = t;
    if (accept) begin
      exp_q.push_back({exp_tkt, t});
      exp_tkt = (exp_tkt == 4'd15) ? 4'd1 : exp_tkt + 4'd1;
    end
    step();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    req = 1'b0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout left=%0d required=0", exp_q.size());
    end
    repeat (3) step();
  endtask

  task automatic do_reset();
    req      = 1'b0;
    issue_en = 1'b1;
    rst_n    = 1'b1;
    repeat (2) step();
    rst_n    = 1'b0;
    exp_q.delete();
    exp_tkt  = 4'd1;
    step();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_num, out_time, pend_cnt, rej, ovf} !== 13'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0",
               {out_valid, out_num, out_time, pend_cnt, rej, ovf});
    end
    repeat (2) step();
    rst_n = 1'b0;
    step();
  endtask

  task automatic test_single();
    do_reset();
    send(4'd8, 1'b1);
    req = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_num !== 4'd1 || out_time !== 4'd8) begin
      failures++;
      $display("FAIL single_latency valid=%b num=%0d time=%0d required 1 1 8",
               out_valid, out_num, out_time);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_width valid=%b required 0", out_valid);
    end
    drain(10);
  endtask

  task automatic test_overflow();
    do_reset();
    send(4'd8, 1'b1);
    send(4'd8, 1'b1);
    send(4'd8, 1'b1);
    checks++;
    if (rej !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_early rej=%b ovf=%b required 0 0", rej, ovf);
    end
    send(4'd1, 1'b0);
    req = 1'b0;
    checks++;
    if (rej !== 1'b1 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_full rej=%b ovf=%b required 1 1", rej, ovf);
    end
    step();
    checks++;
    if (rej !== 1'b0) begin
      failures++;
      $display("FAIL rej_pulse rej=%b required 0", rej);
    end
    drain(20);
    send(4'd5, 1'b1);
    drain(10);
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky ovf=%b required 1", ovf);
    end
  endtask

  task automatic test_zero_time();
    do_reset();
    send(4'd0, 1'b0);
    req = 1'b0;
    checks++;
    if (rej !== 1'b1 || ovf !== 1'b0 || pend_cnt !== 2'd0) begin
      failures++;
      $display("FAIL zero_time rej=%b ovf=%b pend=%0d required 1 0 0",
               rej, ovf, pend_cnt);
    end
    step();
    send(4'd3, 1'b1);
    drain(10);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send(4'((i % 15) + 1), 1'b1);
      drain(10);
    end
    checks++;
    if (exp_tkt !== 4'd2) begin
      failures++;
      $display("FAIL wrap_model tkt=%0d required 2", exp_tkt);
    end
  endtask

  task automatic test_pause();
    int p0;
    do_reset();
    p0 = npulse;
    issue_en = 1'b0;
    send(4'd6, 1'b1);
    send(4'd7, 1'b1);
    req = 1'b0;
    repeat (3) step();
    checks++;
    if (pend_cnt !== 2'd2 || npulse != p0) begin
      failures++;
      $display("FAIL pause_hold pend=%0d pulses=%0d required 2 %0d",
               pend_cnt, npulse, p0);
    end
    issue_en = 1'b1;
    drain(20);
    checks++;
    if (npulse != p0 + 2 || pend_cnt !== 2'd0) begin
      failures++;
      $display("FAIL pause_release pulses=%0d pend=%0d required %0d 0",
               npulse, pend_cnt, p0 + 2);
    end
  endtask

  task automatic test_reset_hold();
    int p0;
    do_reset();
    send(4'd8, 1'b1);
    send(4'd8, 1'b1);
    req = 1'b0;
    checks++;
    if (pend_cnt !== 2'd1) begin
      failures++;
      $display("FAIL hold_pend pend=%0d required 1", pend_cnt);
    end
    rst_n = 1'b1;
    exp_q.delete();
    exp_tkt = 4'd1;
    #1;
    checks++;
    if ({out_valid, out_num, out_time, pend_cnt, rej, ovf} !== 13'd0) begin
      failures++;
      $display("FAIL reset_midop got=%h required=0",
               {out_valid, out_num, out_time, pend_cnt, rej, ovf});
    end
    repeat (2) step();
    rst_n = 1'b0;
    p0 = npulse;
    repeat (6) step();
    checks++;
    if (npulse != p0) begin
      failures++;
      $display("FAIL reset_no_pulse pulses=%0d required %0d", npulse, p0);
    end
    send(4'd2, 1'b1);
    drain(10);
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_zero_time();
    test_wrap();
    test_pause();
    test_reset_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ticket_issuer.md
TICKET_ISSUER -- requirements
Module: ticket_issuer

Interface
REQ-001 SHALL have parameter DT_SZ, default 4: width of the ticket number and the service time.
REQ-002 SHALL have parameter QDEP, default 2: number of accepted requests that can wait for issue.
REQ-003 SHALL have parameter GAP, default 1: minimum idle cycles between two out_valid pulses.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port req, input, 1 bit: kiosk request strobe, sampled every cycle.
REQ-007 SHALL have port req_time, input, DT_SZ bits: requested service time, qualified by req.
REQ-008 SHALL have port issue_en, input, 1 bit: when 0, issuing is paused; requests are still accepted.
REQ-009 SHALL have port out_valid, input-side strobe to the queue stage, output, 1 bit: one-cycle customer pulse.
REQ-010 SHALL have port out_num, output, DT_SZ bits: ticket number; 0 whenever out_valid=0.
REQ-011 SHALL have port out_time, output, DT_SZ bits: service time; 0 whenever out_valid=0.
REQ-012 SHALL have port pend_cnt, output, clog2(QDEP+1) bits: number of requests waiting.
REQ-013 SHALL have port rej, output, 1 bit: one-cycle pulse, the request in the previous cycle was rejected.
REQ-014 SHALL have port ovf, output, 1 bit: sticky flag, at least one request was rejected because the buffer was full.

Function
REQ-015 SHALL accept req when req_time!=0 and the buffer is not full, or when it is full and an entry leaves in the same cycle.
REQ-016 SHALL reject req with req_time==0 and pulse rej without setting ovf.
REQ-017 SHALL reject req when the buffer is full with no entry leaving, pulse rej, and set ovf.
REQ-018 SHALL assign the ticket number at acceptance: counter starts at 1, increments by 1 per acceptance, wraps from 2^DT_SZ-1 to 1, and never issues 0.
REQ-019 SHALL NOT consume a ticket number for a rejected request.
REQ-020 SHALL buffer accepted {num,time} pairs in FIFO order; pend_cnt updates on the edge after accept or issue, and stays unchanged when both happen in the same cycle.
REQ-021 SHALL run a three-state FSM: IDLE, ISSUE, HOLD.
REQ-022 SHALL stay in IDLE while pend_cnt==0 or issue_en==0, and move IDLE->ISSUE when pend_cnt>0 and issue_en==1.
REQ-023 SHALL, in ISSUE, drive out_valid=1 for exactly one cycle with the head entry and pop it.
REQ-024 SHALL move ISSUE->HOLD for GAP cycles, then go to IDLE; with GAP=0, ISSUE->IDLE.
REQ-025 SHALL produce the earliest out_valid the cycle after acceptance into an empty, enabled, idle block (latency 1).
REQ-026 SHALL let issue_en=0 block only the IDLE->ISSUE transition; an ISSUE or HOLD already in progress completes.
REQ-027 SHALL register all outputs; there is no combinational path from any input to any output.

Reset
REQ-028 SHALL, while rst_n is asserted, clear immediately: out_valid, out_num, out_time, pend_cnt, rej, ovf to 0; FSM to IDLE; ticket counter to 1; buffer emptied.
REQ-029 SHALL discard a pending or in-progress issue on reset mid-operation and emit no pulse after release until a new request is accepted.

Structure
REQ-030 SHALL place the FSM state encoding and the ticket-wrap constant in the shared project package used by the queue/counter blocks.
REQ-031 SHALL implement the request buffer as one sub-module, req_fifo, parameterised by width 2*DT_SZ and depth QDEP.

Verification
REQ-032 SHALL cover: single req (time 8) into idle block -> out_valid the next cycle with num=1, time=8; outputs 0 otherwise.
REQ-033 SHALL cover: req on 4 consecutive cycles (times 8,8,8,1), QDEP=2, GAP=1 -> issues num 1,2,3 spaced two cycles apart; the 4th req is rejected, rej pulses, ovf=1, and the next accepted ticket is 4.
REQ-034 SHALL cover: req with time 0 -> rej pulse, ovf stays 0, ticket counter unchanged.
REQ-035 SHALL cover: 16 accepted requests -> tickets 1..15 then 1; 0 never appears on out_num.
REQ-036 SHALL cover: issue_en=0 with 2 accepted requests -> no out_valid and pend_cnt=2; issue_en=1 -> two pulses in FIFO order.
REQ-037 SHALL cover: rst_n asserted in the HOLD state with pend_cnt=1 -> all outputs 0 immediately; no pulse after release; the next ticket is 1.
